// File: rtl/multiplier_iter_if.sv
// Start/working/done handshake bundle between the execute stage and the iterative multiplier.
// Operand and result vectors keep bit 0 as the most significant bit.
interface multiplier_iter_if #(
  parameter int WIDTH = 32
);
  logic                 mul;
  logic                 is_signed;
  logic [0:WIDTH-1]     a;
  logic [0:WIDTH-1]     b;
  logic                 working;
  logic                 done;
  logic [0:2*WIDTH-1]   result;

  modport master (
    output mul, is_signed, a, b,
    input  working, done, result
  );

  modport slave (
    input  mul, is_signed, a, b,
    output working, done, result
  );
endinterface

// File: rtl/multiplier_iter.sv
// Multi-cycle shift-add multiplier: retires DIGIT multiplier bits per RUN cycle on magnitudes,
// then applies the sign in a final FIX cycle. Latency is WIDTH/DIGIT + 2 cycles.
module multiplier_iter #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  multiplier_iter_if.slave   bus_io
);

  localparam int N  = WIDTH / DIGIT;
  localparam int PW = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] magA_q, magA_d;
  logic [WIDTH-1:0] magB_q, magB_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    result_q, result_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] opA, opB;
  logic [PW-1:0]    partial;

  assign opA = bus_io.a;
  assign opB = bus_io.b;

  // Magnitudes are unsigned, so even the most negative operand fits without overflow.
  assign partial = {{WIDTH{1'b0}}, magA_q} * PW'(magB_q[DIGIT-1:0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      magA_q   <= '0;
      magB_q   <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      magA_q   <= magA_d;
      magB_q   <= magB_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    magA_d   = magA_q;
    magB_d   = magB_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus_io.mul) begin
          magA_d  = (bus_io.is_signed && opA[WIDTH-1]) ? -opA : opA;
          magB_d  = (bus_io.is_signed && opB[WIDTH-1]) ? -opB : opB;
          neg_d   = bus_io.is_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
          acc_d   = '0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_q + (partial << (count_q * DIGIT));
        magB_d  = magB_q >> DIGIT;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = neg_q ? -acc_q : acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_io.working = (state_q != IDLE);
  assign bus_io.done    = done_q;
  assign bus_io.result  = result_q;

endmodule

// File: tb/tb_multiplier_iter.sv
// Directed bench for multiplier_iter: 32x32 default instance plus three 16-bit
// instances covering DIGIT = 1, 2 and 16.
module tb_multiplier_iter;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  multiplier_iter_if #(.WIDTH(32)) bus ();
  multiplier_iter_if #(.WIDTH(16)) s0 ();
  multiplier_iter_if #(.WIDTH(16)) s1 ();
  multiplier_iter_if #(.WIDTH(16)) s2 ();

  multiplier_iter #(.WIDTH(32), .DIGIT(4))  dut    (.clk(clk), .reset(reset), .bus_io(bus));
  multiplier_iter #(.WIDTH(16), .DIGIT(1))  dutD1  (.clk(clk), .reset(reset), .bus_io(s0));
  multiplier_iter #(.WIDTH(16), .DIGIT(2))  dutD2  (.clk(clk), .reset(reset), .bus_io(s1));
  multiplier_iter #(.WIDTH(16), .DIGIT(16)) dutD16 (.clk(clk), .reset(reset), .bus_io(s2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation on the 32-bit instance and wait (bounded) for done.
  // lat is the cycle index of done relative to the mul cycle, -1 on timeout.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                        input bit scramble, output logic [63:0] res, output int lat);
    @(negedge clk);
    bus.mul = 1'b1; bus.a = av; bus.b = bv; bus.is_signed = sv;
    lat = -1;
    res = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      bus.mul = 1'b0;
      if (scramble) begin
        bus.a = $urandom; bus.b = $urandom; bus.is_signed = ~bus.is_signed;
      end
      if (bus.done) begin
        lat = c;
        res = bus.result;
      end
    end
  endtask

  task automatic sweep_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, output logic [31:0] res, output int lat);
    logic d;
    @(negedge clk);
    case (k)
      0:       begin s0.mul = 1'b1; s0.a = av; s0.b = bv; s0.is_signed = sv; end
      1:       begin s1.mul = 1'b1; s1.a = av; s1.b = bv; s1.is_signed = sv; end
      default: begin s2.mul = 1'b1; s2.a = av; s2.b = bv; s2.is_signed = sv; end
    endcase
    lat = -1;
    res = '0;
    for (int c = 1; c <= 24 && lat < 0; c++) begin
      @(negedge clk);
      s0.mul = 1'b0; s1.mul = 1'b0; s2.mul = 1'b0;
      case (k)
        0:       begin d = s0.done; res = s0.result; end
        1:       begin d = s1.done; res = s1.result; end
        default: begin d = s2.done; res = s2.result; end
      endcase
      if (d) lat = c;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if (bus.working !== 1'b0) $display("[TB] FAIL reset_working got %b want 0", bus.working);
    else passCount++;
    checkCount++;
    if (bus.done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", bus.done);
    else passCount++;
    checkCount++;
    if (bus.result !== 64'h0) $display("[TB] FAIL reset_result got %h want 0", bus.result);
    else passCount++;
    reset = 1'b1;
  endtask

  task automatic test_unsigned_max();
    logic expW, expD;
    @(negedge clk);
    bus.mul = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.is_signed = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.mul = 1'b0;
      expW = (c <= 9);
      expD = (c == 10);
      checkCount++;
      if (bus.working !== expW) $display("[TB] FAIL umax_working cycle %0d got %b want %b", c, bus.working, expW);
      else passCount++;
      checkCount++;
      if (bus.done !== expD) $display("[TB] FAIL umax_done cycle %0d got %b want %b", c, bus.done, expD);
      else passCount++;
      if (c == 10) begin
        checkCount++;
        if (bus.result !== 64'hFFFF_FFFE_0000_0001)
          $display("[TB] FAIL umax_result got %h want fffffffe00000001", bus.result);
        else passCount++;
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] va [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000,
                            32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] vb [7] = '{32'h0000_0005, 32'h0000_0005, 32'h8000_0000, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0010};
    logic        vs [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] ve [7] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0004_FFFF_FFF1,
                            64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
                            64'h0, 64'h1, 64'h0000_0001_2345_6780};
    logic [63:0] res;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], vs[i], 1'b0, res, lat);
      checkCount++;
      if (res !== ve[i]) $display("[TB] FAIL vec%0d_result got %h want %h", i, res, ve[i]);
      else passCount++;
      checkCount++;
      if (lat !== 10) $display("[TB] FAIL vec%0d_latency got %0d want 10", i, lat);
      else passCount++;
    end
  endtask

  task automatic test_back_to_back();
    logic expW, expD;
    @(negedge clk);
    bus.mul = 1'b1; bus.a = 32'd2; bus.b = 32'd3; bus.is_signed = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      if (c == 30) bus.mul = 1'b0;
      expD = (c == 10 || c == 20 || c == 30);
      expW = (c < 30) && !expD;
      checkCount++;
      if (bus.done !== expD) $display("[TB] FAIL b2b_done cycle %0d got %b want %b", c, bus.done, expD);
      else passCount++;
      checkCount++;
      if (bus.working !== expW) $display("[TB] FAIL b2b_working cycle %0d got %b want %b", c, bus.working, expW);
      else passCount++;
      if (expD) begin
        checkCount++;
        if (bus.result !== 64'd6) $display("[TB] FAIL b2b_result cycle %0d got %h want 6", c, bus.result);
        else passCount++;
      end
    end
  endtask

  task automatic test_operand_change();
    logic [63:0] res;
    int          lat;
    run_op(32'h0000_1234, 32'h0000_0010, 1'b0, 1'b1, res, lat);
    checkCount++;
    if (res !== 64'h0001_2340) $display("[TB] FAIL scramble_result got %h want 12340", res);
    else passCount++;
    checkCount++;
    if (lat !== 10) $display("[TB] FAIL scramble_latency got %0d want 10", lat);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int          lat;
    int          doneSeen;
    @(negedge clk);
    bus.mul = 1'b1; bus.a = 32'd5; bus.b = 32'd7; bus.is_signed = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.mul = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkCount++;
    if (bus.working !== 1'b0) $display("[TB] FAIL midreset_working got %b want 0", bus.working);
    else passCount++;
    checkCount++;
    if (bus.result !== 64'h0) $display("[TB] FAIL midreset_result got %h want 0", bus.result);
    else passCount++;
    reset = 1'b1;
    doneSeen = (bus.done === 1'b1) ? 1 : 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
    end
    checkCount++;
    if (doneSeen !== 0) $display("[TB] FAIL midreset_nodone got %0d pulses want 0", doneSeen);
    else passCount++;
    run_op(32'd9, 32'd11, 1'b0, 1'b0, res, lat);
    checkCount++;
    if (res !== 64'd99) $display("[TB] FAIL postreset_result got %h want 63", res);
    else passCount++;
    checkCount++;
    if (lat !== 10) $display("[TB] FAIL postreset_latency got %0d want 10", lat);
    else passCount++;
  endtask

  task automatic test_sweep();
    int                 expLat [3] = '{18, 10, 3};
    logic [15:0]        av, bv;
    logic signed [15:0] sa, sb;
    logic               sv;
    logic [31:0]        want, res;
    int                 lat;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        av = 16'($urandom);
        bv = 16'($urandom);
        if (i == 0) begin av = 16'h8000; bv = 16'h8000; end
        sv = (i % 2 == 0);
        sa = av;
        sb = bv;
        if (sv) want = sa * sb;
        else    want = av * bv;
        sweep_op(k, av, bv, sv, res, lat);
        checkCount++;
        if (res !== want)
          $display("[TB] FAIL sweep%0d_result a=%h b=%h s=%b got %h want %h", k, av, bv, sv, res, want);
        else passCount++;
        checkCount++;
        if (lat !== expLat[k]) $display("[TB] FAIL sweep%0d_latency got %0d want %0d", k, lat, expLat[k]);
        else passCount++;
      end
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset = 1'b0;
    bus.mul = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
    s0.mul  = 1'b0; s0.a  = '0; s0.b  = '0; s0.is_signed  = 1'b0;
    s1.mul  = 1'b0; s1.a  = '0; s1.b  = '0; s1.is_signed  = 1'b0;
    s2.mul  = 1'b0; s2.a  = '0; s2.b  = '0; s2.is_signed  = 1'b0;

    test_reset();
    test_unsigned_max();
    test_signed();
    test_back_to_back();
    test_operand_change();
    test_reset_mid();
    test_sweep();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multiplier_iter.md
# multiplier_iter

Parametrised multi-cycle integer multiplier for the execute stage. It multiplies two WIDTH-bit operands in signed or unsigned mode and produces the full 2·WIDTH-bit product. It retires DIGIT multiplier bits per cycle through a shift-add datapath, so latency and area trade off through a single parameter. It replaces the fixed 32-bit, unsigned-only multiplier and uses the same start/working/done style of handshake toward pipeline stall logic.

## Interface
- WIDTH, 32: operand width in bits; must be ≥ 4.
- DIGIT, 4: multiplier bits consumed per iteration; must divide WIDTH. Iteration count N = WIDTH/DIGIT.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low.
- mul  in  1  start request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operands and result; 0 = unsigned. Sampled with mul.
- a  in  WIDTH  multiplicand, bit 0 = MSB.
- b  in  WIDTH  multiplier, bit 0 = MSB.
- working  out  1  high while an operation is in flight (state ≠ IDLE).
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  2·WIDTH  product, bit 0 = MSB; registered; holds until the next done.

## Operation
- States:
  - IDLE: waits for mul.
  - RUN: performs N iterations.
  - FIX: applies the sign, loads result, and asserts done.
- IDLE, mul=1:
  - Latch mag_a = |a| and mag_b = |b| if is_signed, otherwise a and b unchanged.
  - Latch neg = is_signed & (a[0] ^ b[0]).
  - Clear acc (2·WIDTH) and the iteration counter.
  - Go to RUN.
- IDLE, mul=0: remain in IDLE.
- RUN, each cycle:
  - acc += (mag_a · low DIGIT bits of mag_b) << (count·DIGIT).
  - Shift mag_b right by DIGIT; count++.
  - After the Nth iteration, go to FIX.
- FIX:
  - result ← neg ? −acc : acc, computed mod 2^(2·WIDTH).
  - done ← 1; go to IDLE.
- Magnitudes are WIDTH-bit unsigned. The magnitude of −2^(WIDTH−1) is 2^(WIDTH−1), which fits, so no overflow is possible. −2^(WIDTH−1) · −2^(WIDTH−1) = 2^(2·WIDTH−2), positive.
- Zero operands: acc stays 0; neg may be set, and −0 = 0.
- mul while working: ignored; no queueing. a, b and is_signed may change freely after the mul cycle.
- Reset (reset=0 at an edge), including mid-operation:
  - State ← IDLE.
  - working=0, done=0, result=0, acc=0, counter=0.
  - The in-flight operation is discarded and done is never raised for it.

## Timing
- Reset values: working=0, done=0, result=0.
- mul=1 in cycle 0 (IDLE):
  - working=1 in cycles 1..N+1; RUN occupies cycles 1..N, FIX is cycle N+1.
  - done=1 and result valid in cycle N+2; working=0 in that cycle.
- Total latency N+2 cycles; default N=8, so done arrives in cycle 10.
- Back-to-back: mul=1 in the done cycle (N+2) is accepted. Throughput is one operation per N+2 cycles.
- done is a single-cycle pulse. working and done are never high together.
- working is registered and derived from the state, not combinationally from mul.

## Test plan
- Unsigned, WIDTH=32, DIGIT=4: a=0xFFFFFFFF, b=0xFFFFFFFF, mul pulse in cycle 0 -> done only in cycle 10; result=0xFFFFFFFE00000001; working high in cycles 1–9.
- Signed: a=0xFFFFFFFD (−3), b=5 -> result=0xFFFFFFFFFFFFFFF1. Signed a=0x80000000, b=0x80000000 -> result=0x4000000000000000. Unsigned with the same operands -> 0x4000000000000000.
- Zero and sign: signed a=0, b=0xFFFFFFFF -> result=0. Signed a=0xFFFFFFFF, b=0xFFFFFFFF -> result=1.
- Handshake:
  - mul held high for 30 cycles with a=2, b=3 -> operations start in cycles 0, 10 and 20; done in cycles 10, 20 and 30; each result=6.
  - Operand changes during working do not affect the result.
- Reset mid-operation: reset=0 in cycle 4 -> working=0 and result=0 from the next cycle; no done pulse. A fresh mul then completes normally with the correct product.
- Parameter sweep: WIDTH=16 with DIGIT ∈ {1, 2, 16}, 1000 random signed and unsigned vectors each -> result matches the reference product; done arrives exactly N+2 cycles after mul (N = 16, 8, 1).
